load_store_unit: RTL and testbench

- Multi-cycle initiator for the word-wide data memory port: Address/WriteData/MemWrite/MemRead/ReadData.
- The memory has combinational read, writes on the clk rising edge, and is word-addressed from a byte address.
- Sits between the MIPS core and the data memory. Adds byte and halfword loads and stores, using read-modify-write for sub-word stores.
- Also checks alignment and address range, and reports completion with a done pulse.

---
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Word-wide data memory port between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic                  mem_write;
   logic                  mem_read;
   logic [DATA_WIDTH-1:0] mem_read_data;

   modport master (
      output mem_address, mem_write_data, mem_write, mem_read,
      input  mem_read_data
   );

   modport slave (
      input  mem_address, mem_write_data, mem_write, mem_read,
      output mem_read_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator adding byte/half accesses (RMW for sub-word stores).
// Define LSU_ALIGN_CHECK_EN to fault misaligned and out-of-range requests.
module load_store_unit #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
   parameter int unsigned           MEMORY_DEPTH = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  is_store,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  fault,
   load_store_unit_if.master     mem
);

   typedef enum logic [2:0] {
      S_IDLE, S_LD, S_ST, S_RMW_RD, S_RMW_WR, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [1:0]            lane_q, lane_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] merge_q, merge_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
   logic                  fault_q, fault_d;
   logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;

   logic                  illegal_op;
   logic                  req_fault;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [DATA_WIDTH-1:0] ld_value;
   logic [DATA_WIDTH-1:0] merged;

`ifdef LSU_ALIGN_CHECK_EN
   localparam logic [DATA_WIDTH-1:0] LAST_ADDR = BASE_ADDR + DATA_WIDTH'(4 * MEMORY_DEPTH - 1);
   logic misaligned;
   logic out_of_range;
`else
   logic unused_range_cfg;
   assign unused_range_cfg = ^{BASE_ADDR, 32'(MEMORY_DEPTH)};
`endif

   always_comb begin
      illegal_op = (op == 3'b011) || (op[2:1] == 2'b11) || (is_store && op[2]);
`ifdef LSU_ALIGN_CHECK_EN
      misaligned   = ((op[1:0] == 2'b01) && address[0]) ||
                     ((op[1:0] == 2'b10) && (address[1:0] != 2'b00));
      out_of_range = (address < BASE_ADDR) || (address > LAST_ADDR);
      req_fault    = illegal_op || misaligned || out_of_range;
`else
      req_fault    = illegal_op;
`endif
   end

   // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1]; op[2] selects zero-extension.
   always_comb begin
      rd_byte = mem.mem_read_data[{lane_q, 3'b000} +: 8];
      rd_half = mem.mem_read_data[{lane_q[1], 4'b0000} +: 16];
      case (op_q[1:0])
         2'b00:   ld_value = {{(DATA_WIDTH-8){rd_byte[7] & ~op_q[2]}}, rd_byte};
         2'b01:   ld_value = {{(DATA_WIDTH-16){rd_half[15] & ~op_q[2]}}, rd_half};
         default: ld_value = mem.mem_read_data;
      endcase
      merged = merge_q;
      if (op_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
      else         merged[{lane_q, 3'b000} +: 8]      = data_q[7:0];
   end

   always_comb begin
      state_d            = state_q;
      op_d               = op_q;
      lane_d             = lane_q;
      data_d             = data_q;
      merge_d            = merge_q;
      load_data_d        = load_data_q;
      fault_d            = fault_q;
      mem_addr_d         = mem_addr_q;
      mem.mem_read       = 1'b0;
      mem.mem_write      = 1'b0;
      mem.mem_write_data = data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               lane_d  = address[1:0];
               data_d  = store_data;
               fault_d = req_fault;
               if (req_fault) begin
                  state_d = S_DONE;
               end else begin
                  mem_addr_d = {address[DATA_WIDTH-1:2], 2'b00};
                  if (!is_store)  state_d = S_LD;
                  else if (op[1]) state_d = S_ST;
                  else            state_d = S_RMW_RD;
               end
            end
         end
         S_LD: begin
            mem.mem_read = 1'b1;
            load_data_d  = ld_value;
            state_d      = S_DONE;
         end
         S_ST: begin
            // Write is suppressed during reset so an aborted access never reaches memory.
            mem.mem_write = !reset;
            state_d       = S_DONE;
         end
         S_RMW_RD: begin
            mem.mem_read = 1'b1;
            merge_d      = mem.mem_read_data;
            state_d      = S_RMW_WR;
         end
         S_RMW_WR: begin
            mem.mem_write      = !reset;
            mem.mem_write_data = merged;
            state_d            = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         lane_q      <= '0;
         data_q      <= '0;
         merge_q     <= '0;
         load_data_q <= '0;
         fault_q     <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lane_q      <= lane_d;
         data_q      <= data_d;
         merge_q     <= merge_d;
         load_data_q <= load_data_d;
         fault_q     <= fault_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_DONE);
   assign fault           = fault_q;
   assign load_data       = load_data_q;
   assign mem.mem_address = mem_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops against a reference model.
module tb_load_store_unit;
   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_store = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] address = '0, store_data = '0;
   logic        busy, done, fault;
   logic [31:0] load_data;

   logic [31:0] mem     [DEPTH] = '{default: '0};
   logic [31:0] ref_mem [DEPTH] = '{default: '0};
   logic [31:0] last_ld = '0;
   int          n_cmp = 0, n_bad = 0;

   load_store_unit_if #(.DATA_WIDTH(32)) mif ();

   load_store_unit #(.DATA_WIDTH(32), .BASE_ADDR(BASE), .MEMORY_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store), .op(op),
      .address(address), .store_data(store_data), .busy(busy), .done(done),
      .load_data(load_data), .fault(fault), .mem(mif)
   );

   always #5 clk = ~clk;

   assign mif.mem_read_data = mem[mif.mem_address[11:2]];
   always @(posedge clk) if (mif.mem_write) mem[mif.mem_address[11:2]] <= mif.mem_write_data;

   // ---------------- reference model ----------------
   function automatic int op_size(logic [2:0] o);
      return (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit model_fault(bit st, logic [2:0] o, logic [31:0] a);
      bit legal;
      legal = st ? (o inside {3'd0, 3'd1, 3'd2}) : (o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
      if ((a % op_size(o)) != 0) return 1'b1;
      if (a < BASE || a >= BASE + 32'(4 * DEPTH)) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic int lane_off(logic [2:0] o, logic [31:0] a);
      int sz = op_size(o);
      return (int'(a[1:0]) / sz) * sz;
   endfunction

   function automatic logic [31:0] size_mask(logic [2:0] o);
      int sz = op_size(o);
      return (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] w, logic [2:0] o, logic [31:0] a);
      logic [31:0] m, v;
      int sz = op_size(o);
      m = size_mask(o);
      v = (w >> (8 * lane_off(o, a))) & m;
      if (!o[2] && sz != 4 && v[8*sz-1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [31:0] model_store(logic [31:0] w, logic [2:0] o, logic [31:0] a, logic [31:0] d);
      logic [31:0] m;
      int sh = 8 * lane_off(o, a);
      m = size_mask(o);
      return (w & ~(m << sh)) | ((d & m) << sh);
   endfunction

   // ---------------- driver ----------------
   task automatic do_op(input bit st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int nwr, output int nrd, output int nboth,
                        output logic [31:0] wa, output logic [31:0] wd, output logic flt);
      is_store = st; op = o; address = a; store_data = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; is_store = ~st; op = ~o; address = ~a; store_data = ~d;
      lat = 1; nwr = 0; nrd = 0; nboth = 0; wa = '0; wd = '0;
      while (1) begin
         if (mif.mem_write === 1'b1) begin nwr++; wa = mif.mem_address; wd = mif.mem_write_data; end
         if (mif.mem_read === 1'b1) nrd++;
         if (mif.mem_write === 1'b1 && mif.mem_read === 1'b1) nboth++;
         if (done === 1'b1 || lat >= 10) break;
         @(posedge clk); #1; lat++;
      end
      flt = fault;
      if (done !== 1'b1) lat = -1;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
      n_cmp++; if (mif.mem_write !== 1'b0 || mif.mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ctl: got wr=%b rd=%b want 0 0", mif.mem_write, mif.mem_read); end
      n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL reset_load_data: got %h want 00000000", load_data); end
      reset = 1'b0; last_ld = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_word_store_load();
      int lat, nwr, nrd, nb; logic [31:0] wa, wd; logic flt;
      do_op(1'b1, 3'b010, 32'h1001_0008, 32'hDEAD_BEEF, lat, nwr, nrd, nb, wa, wd, flt);
      ref_mem[2] = 32'hDEAD_BEEF;
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
      n_cmp++; if (nwr !== 1 || nrd !== 0) begin n_bad++; $display("FAIL sw_accesses: got wr=%0d rd=%0d want 1 0", nwr, nrd); end
      n_cmp++; if (wa !== 32'h1001_0008 || wd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_bus: got %h/%h want 10010008/deadbeef", wa, wd); end
      n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL sw_fault: got %b want 0", flt); end
      do_op(1'b0, 3'b010, 32'h1001_0008, 32'h0, lat, nwr, nrd, nb, wa, wd, flt);
      last_ld = 32'hDEAD_BEEF;
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
      n_cmp++; if (load_data !== 32'hDEAD_BEEF || flt !== 1'b0) begin n_bad++; $display("FAIL lw_data: got %h fault=%b want deadbeef fault=0", load_data, flt); end
   endtask

   task automatic test_byte_loads();
      int lat, nwr, nrd, nb; logic [31:0] wa, wd; logic flt;
      logic [2:0]  lo [3] = '{3'b000, 3'b100, 3'b000};
      logic [31:0] la [3] = '{32'h1001_0003, 32'h1001_0003, 32'h1001_0001};
      logic [31:0] le [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F};
      do_op(1'b1, 3'b010, 32'h1001_0000, 32'h80FF_7F01, lat, nwr, nrd, nb, wa, wd, flt);
      ref_mem[0] = 32'h80FF_7F01;
      for (int i = 0; i < 3; i++) begin
         do_op(1'b0, lo[i], la[i], 32'h0, lat, nwr, nrd, nb, wa, wd, flt);
         last_ld = le[i];
         n_cmp++; if (load_data !== le[i] || flt !== 1'b0 || lat !== 2) begin n_bad++; $display("FAIL byte_load%0d: got %h fault=%b lat=%0d want %h fault=0 lat=2", i, load_data, flt, lat, le[i]); end
      end
   endtask

   task automatic test_half_rmw();
      int lat, nwr, nrd, nb; logic [31:0] wa, wd; logic flt;
      do_op(1'b1, 3'b010, 32'h1001_0010, 32'h1122_3344, lat, nwr, nrd, nb, wa, wd, flt);
      do_op(1'b1, 3'b001, 32'h1001_0012, 32'h5555_ABCD, lat, nwr, nrd, nb, wa, wd, flt);
      ref_mem[4] = 32'hABCD_3344;
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sh_latency: got %0d want 3", lat); end
      n_cmp++; if (nrd !== 1 || nwr !== 1 || nb !== 0) begin n_bad++; $display("FAIL sh_accesses: got rd=%0d wr=%0d both=%0d want 1 1 0", nrd, nwr, nb); end
      n_cmp++; if (wa !== 32'h1001_0010 || wd !== 32'hABCD_3344) begin n_bad++; $display("FAIL sh_bus: got %h/%h want 10010010/abcd3344", wa, wd); end
      n_cmp++; if (mem[4] !== 32'hABCD_3344) begin n_bad++; $display("FAIL sh_memory: got %h want abcd3344", mem[4]); end
   endtask

   task automatic test_faults();
      int lat, nwr, nrd, nb; logic [31:0] wa, wd; logic flt;
      logic [2:0] fo [3] = '{3'b100, 3'b011, 3'b110};
      bit         fs [3] = '{1'b1, 1'b0, 1'b0};
`ifdef LSU_ALIGN_CHECK_EN
      logic [2:0]  ao [3] = '{3'b001, 3'b010, 3'b010};
      logic [31:0] aa [3] = '{32'h1001_0001, 32'h1001_0002, 32'h1001_1000};
`endif
      for (int i = 0; i < 3; i++) begin
         do_op(fs[i], fo[i], 32'h1001_0000, 32'h1234_5678, lat, nwr, nrd, nb, wa, wd, flt);
         n_cmp++; if (flt !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL illegal_op%0d: got fault=%b lat=%0d want fault=1 lat=1", i, flt, lat); end
         n_cmp++; if (nwr !== 0 || nrd !== 0 || load_data !== last_ld) begin n_bad++; $display("FAIL illegal_side%0d: got wr=%0d rd=%0d ld=%h want 0 0 %h", i, nwr, nrd, load_data, last_ld); end
      end
`ifdef LSU_ALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         do_op(1'b0, ao[i], aa[i], 32'h0, lat, nwr, nrd, nb, wa, wd, flt);
         n_cmp++; if (flt !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL align_fault%0d: got fault=%b lat=%0d want fault=1 lat=1", i, flt, lat); end
         n_cmp++; if (nwr !== 0 || nrd !== 0 || load_data !== last_ld) begin n_bad++; $display("FAIL align_side%0d: got wr=%0d rd=%0d ld=%h want 0 0 %h", i, nwr, nrd, load_data, last_ld); end
      end
`else
      do_op(1'b0, 3'b010, 32'h1001_0002, 32'h0, lat, nwr, nrd, nb, wa, wd, flt);
      last_ld = 32'h80FF_7F01;
      n_cmp++; if (flt !== 1'b0 || load_data !== 32'h80FF_7F01) begin n_bad++; $display("FAIL unaligned_lw: got %h fault=%b want 80ff7f01 fault=0", load_data, flt); end
      do_op(1'b0, 3'b001, 32'h1001_0001, 32'h0, lat, nwr, nrd, nb, wa, wd, flt);
      last_ld = 32'h0000_7F01;
      n_cmp++; if (flt !== 1'b0 || load_data !== 32'h0000_7F01) begin n_bad++; $display("FAIL unaligned_lh: got %h fault=%b want 00007f01 fault=0", load_data, flt); end
`endif
   endtask

   task automatic test_reset_mid_rmw();
      is_store = 1'b1; op = 3'b000; address = 32'h1001_0020; store_data = 32'h0000_0055; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (mif.mem_read !== 1'b1) begin n_bad++; $display("FAIL rmw_read_phase: got rd=%b want 1", mif.mem_read); end
      @(posedge clk); #1;
      n_cmp++; if (mif.mem_write !== 1'b1) begin n_bad++; $display("FAIL rmw_write_phase: got wr=%b want 1", mif.mem_write); end
      reset = 1'b1; #1;
      n_cmp++; if (mif.mem_write !== 1'b0) begin n_bad++; $display("FAIL rmw_reset_gate: got wr=%b want 0", mif.mem_write); end
      @(posedge clk); #1;
      reset = 1'b0; last_ld = '0;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rmw_reset_state: got busy=%b done=%b want 0 0", busy, done); end
      n_cmp++; if (mem[8] !== 32'h0) begin n_bad++; $display("FAIL rmw_reset_memory: got %h want 00000000", mem[8]); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0 || load_data !== 32'h0) begin n_bad++; $display("FAIL rmw_reset_after: got done=%b ld=%h want 0 00000000", done, load_data); end
   endtask

   task automatic test_busy_ignore();
      int lat, nwr, nrd, nb, dones; logic [31:0] wa, wd; logic flt;
      do_op(1'b1, 3'b010, 32'h1001_0004, 32'h600D_F00D, lat, nwr, nrd, nb, wa, wd, flt);
      ref_mem[1] = 32'h600D_F00D;
      is_store = 1'b1; op = 3'b000; address = 32'h1001_0030; store_data = 32'h0000_00A5; start = 1'b1;
      @(posedge clk); #1;
      dones = (done === 1'b1) ? 1 : 0;
      is_store = 1'b0; op = 3'b010; address = 32'h1001_0004; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones += (done === 1'b1) ? 1 : 0;
      repeat (6) begin @(posedge clk); #1; dones += (done === 1'b1) ? 1 : 0; end
      ref_mem[12] = model_store(32'h0, 3'b000, 32'h1001_0030, 32'h0000_00A5);
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", dones); end
      n_cmp++; if (load_data !== last_ld || busy !== 1'b0) begin n_bad++; $display("FAIL busy_ignored_load: got ld=%h busy=%b want %h 0", load_data, busy, last_ld); end
      n_cmp++; if (mem[12] !== ref_mem[12]) begin n_bad++; $display("FAIL busy_sb_memory: got %h want %h", mem[12], ref_mem[12]); end
      do_op(1'b0, 3'b010, 32'h1001_0004, 32'h0, lat, nwr, nrd, nb, wa, wd, flt);
      last_ld = 32'h600D_F00D;
      n_cmp++; if (lat !== 2 || load_data !== 32'h600D_F00D) begin n_bad++; $display("FAIL busy_later_lw: got %h lat=%0d want 600df00d lat=2", load_data, lat); end
   endtask

   task automatic test_random(int n);
      bit st, ef; logic [2:0] o; logic [31:0] a, d, wa, wd; logic flt;
      int lat, nwr, nrd, nb, idx, exp_lat, exp_wr, exp_rd;
      for (int i = 0; i < n; i++) begin
         st = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 11))
            0, 1:    o = 3'd0;
            2, 3:    o = 3'd1;
            4, 5:    o = 3'd2;
            6, 7:    o = 3'd4;
            8, 9:    o = 3'd5;
            default: o = 3'($urandom_range(0, 7));
         endcase
         a = BASE + 32'(4 * $urandom_range(16, 63)) + 32'($urandom_range(0, 3));
`ifdef LSU_ALIGN_CHECK_EN
         if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 8))
                                            : BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 31));
`endif
         d  = $urandom;
         ef = model_fault(st, o, a);
         exp_lat = ef ? 1 : (st && op_size(o) < 4) ? 3 : 2;
         exp_wr  = (!ef && st) ? 1 : 0;
         exp_rd  = (!ef && (!st || op_size(o) < 4)) ? 1 : 0;
         do_op(st, o, a, d, lat, nwr, nrd, nb, wa, wd, flt);
         n_cmp++; if (lat !== exp_lat || flt !== ef) begin n_bad++; $display("FAIL rnd%0d_timing: got lat=%0d fault=%b want lat=%0d fault=%b (st=%b op=%0d a=%h)", i, lat, flt, exp_lat, ef, st, o, a); end
         n_cmp++; if (nwr !== exp_wr || nrd !== exp_rd || nb !== 0) begin n_bad++; $display("FAIL rnd%0d_access: got wr=%0d rd=%0d both=%0d want %0d %0d 0", i, nwr, nrd, nb, exp_wr, exp_rd); end
         if (!ef) begin
            idx = int'((a - BASE) >> 2);
            if (st) begin
               ref_mem[idx] = model_store(ref_mem[idx], o, a, d);
               n_cmp++; if (wa !== {a[31:2], 2'b00} || wd !== ref_mem[idx]) begin n_bad++; $display("FAIL rnd%0d_store_bus: got %h/%h want %h/%h", i, wa, wd, {a[31:2], 2'b00}, ref_mem[idx]); end
               n_cmp++; if (mem[idx] !== ref_mem[idx]) begin n_bad++; $display("FAIL rnd%0d_store_mem: got %h want %h", i, mem[idx], ref_mem[idx]); end
            end else begin
               last_ld = model_load(ref_mem[idx], o, a);
            end
         end
         n_cmp++; if (load_data !== last_ld) begin n_bad++; $display("FAIL rnd%0d_load_data: got %h want %h (st=%b op=%0d a=%h)", i, load_data, last_ld, st, o, a); end
      end
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_byte_loads();
      test_half_rmw();
      test_faults();
      test_reset_mid_rmw();
      test_busy_ignore();
      test_random(200);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion want finish within time limit");
      $fatal(1);
   end
endmodule
